// File: rtl/irq_pkg.sv
// irq_pkg -- shared constants for the memory-mapped interrupt controller.
//   Register addresses, source count/indices, ACK mask width and the
//   address decoder used by irq_controller.
package irq_pkg;

  localparam logic [31:0] ADDR_CYCLE   = 32'hffff_001c;
  localparam logic [31:0] ADDR_ACK     = 32'hffff_006c;
  localparam logic [31:0] ADDR_MASK    = 32'hffff_0070;
  localparam logic [31:0] ADDR_PENDING = 32'hffff_0074;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned SRC_TIMER = 0;
  localparam int unsigned SRC_EXT1  = 1;
  localparam int unsigned SRC_EXT2  = 2;
  localparam int unsigned SRC_EXT3  = 3;
  localparam int unsigned ACK_W     = NUM_SRC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CYCLE,
    REG_ACK,
    REG_MASK,
    REG_PENDING
  } reg_e;

  function automatic reg_e decode(input logic [31:0] addr);
    case (addr)
      ADDR_CYCLE:   return REG_CYCLE;
      ADDR_ACK:     return REG_ACK;
      ADDR_MASK:    return REG_MASK;
      ADDR_PENDING: return REG_PENDING;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect -- rising-edge detector for one external interrupt line.
//   clock : system clock
//   reset : synchronous active-high reset; all flops load the live level
//           so a line already high does not produce a pulse afterwards
//   level : raw interrupt level
//   rise  : one-cycle pulse on a 0->1 transition of the (optionally
//           synchronised) level
// Build option: IRQ_EXT_SYNC_EN inserts a two-flop synchroniser in front
// of the edge detector (2 cycles extra latency).
module irq_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic seen;
  logic prev;

`ifdef IRQ_EXT_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= level;
      sync2 <= level;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
    end
  end

  assign seen = sync2;
`else
  assign seen = level;
`endif

  always_ff @(posedge clock) begin
    if (reset) prev <= level;
    else       prev <= seen;
  end

  assign rise = seen & ~prev;

endmodule

// File: rtl/irq_controller.sv
// irq_controller -- memory-mapped timer/external interrupt controller.
//   clock, reset : system clock, synchronous active-high reset
//   address      : MMIO address; wr_data : store data
//   MemRead      : load strobe; MemWrite : store strobe
//   ext_irq      : level lines for sources 1..3
//   rd_data      : combinational read data (0 on no hit)
//   hit          : address decodes to a controller register
//   IrqOut       : any enabled pending source
//   IrqId        : lowest-index enabled pending source (0 if none)
// Build option: IRQ_EXT_SYNC_EN (see irq_edge_detect).
module irq_controller
  import irq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  ext_irq,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        IrqOut,
  output logic [1:0]  IrqId
);

  logic [31:0]        counter;
  logic [31:0]        compare;
  logic [ACK_W-1:0]   mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] set;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:1] ext_rise;
  reg_e               sel;
  logic               wr_cycle;
  logic               wr_ack;
  logic               wr_mask;

  for (genvar n = SRC_EXT1; n <= SRC_EXT3; n++) begin : g_ext
    irq_edge_detect u_edge (
      .clock (clock),
      .reset (reset),
      .level (ext_irq[n-1]),
      .rise  (ext_rise[n])
    );
  end

  // Decode and reads are combinational, so a simultaneous load+store
  // naturally returns the value from before the store lands.
  always_comb begin
    sel     = decode(address);
    hit     = (sel != REG_NONE);
    rd_data = '0;
    case (sel)
      REG_CYCLE:   rd_data = counter;
      REG_MASK:    rd_data = {{(32-ACK_W){1'b0}}, mask};
      REG_PENDING: rd_data = {{(32-NUM_SRC){1'b0}}, pending};
      default:     rd_data = '0;
    endcase
  end

  assign wr_cycle = MemWrite && (sel == REG_CYCLE);
  assign wr_ack   = MemWrite && (sel == REG_ACK);
  assign wr_mask  = MemWrite && (sel == REG_MASK);
  assign ack_clr  = wr_ack ? wr_data[ACK_W-1:0] : '0;

  // The match uses the registered compare, so a compare written this
  // cycle only participates from the following edge.
  assign set = {ext_rise, (counter == compare)};

  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
      compare <= '1;
      mask    <= '0;
      pending <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (wr_cycle) compare <= wr_data;
      if (wr_mask)  mask    <= wr_data[ACK_W-1:0];
      // A new set beats an ACK of the same bit.
      pending <= (pending & ~ack_clr) | set;
    end
  end

  always_comb begin
    IrqOut = |(pending & mask);
    IrqId  = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (pending[i-1] && mask[i-1]) IrqId = 2'(i-1);
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller -- scoreboard bench for irq_controller.
// A driver issues one bus/ext_irq stimulus per cycle and pushes the
// outputs predicted by a register-level reference model; a monitor pops
// and compares on the falling edge.
module tb_irq_controller;
  import irq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] wr_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  ext_irq = '0;
  logic [31:0] rd_data;
  logic        hit;
  logic        IrqOut;
  logic [1:0]  IrqId;

  irq_controller dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .wr_data  (wr_data),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ext_irq  (ext_irq),
    .rd_data  (rd_data),
    .hit      (hit),
    .IrqOut   (IrqOut),
    .IrqId    (IrqId)
  );

  always #5 clock = ~clock;

`ifdef IRQ_EXT_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        hit;
    logic        irq;
    logic [1:0]  id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done = 0;

  // Reference model state
  bit [31:0] m_cnt, m_cmp;
  bit [3:0]  m_mask, m_pend;
  bit [2:0]  past[3];      // past[k] = ext_irq value k+1 cycles ago
  bit        m_valid = 0;
  bit [2:0]  cur_ext = '0;

  task automatic cycle(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                       input bit rd, input bit wr, input logic [2:0] ext);
    exp_t e;
    bit [3:0] s;
    bit [3:0] clr;
    bit [2:0] now_v, prev_v;
    @(posedge clock);
    #1;
    reset = rst; address = a; wr_data = wd; MemRead = rd; MemWrite = wr; ext_irq = ext;
    if (m_valid) begin
      e.hit = (a == ADDR_CYCLE) || (a == ADDR_ACK) || (a == ADDR_MASK) || (a == ADDR_PENDING);
      e.rd  = (a == ADDR_CYCLE) ? m_cnt :
              (a == ADDR_MASK) ? {28'd0, m_mask} :
              (a == ADDR_PENDING) ? {28'd0, m_pend} : 32'd0;
      e.irq = ((m_pend & m_mask) != 0);
      e.id  = 0;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) e.id = 2'(i);
      q.push_back(e);
    end
    if (rst) begin
      m_cnt = 0; m_cmp = 32'hffff_ffff; m_mask = 0; m_pend = 0;
      for (int k = 0; k < 3; k++) past[k] = ext;
      m_valid = 1;
    end else begin
      now_v  = (DLY == 0) ? ext : past[DLY-1];
      prev_v = past[DLY];
      s   = {now_v & ~prev_v, (m_cnt == m_cmp)};
      clr = (wr && a == ADDR_ACK) ? wd[3:0] : 4'd0;
      m_pend = (m_pend & ~clr) | s;
      if (wr && a == ADDR_CYCLE) m_cmp = wd;
      if (wr && a == ADDR_MASK)  m_mask = wd[3:0];
      m_cnt = m_cnt + 1;
      past[2] = past[1]; past[1] = past[0]; past[0] = ext;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'd0, 32'd0, 0, 0, cur_ext);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(0, a, d, 0, 1, cur_ext);
  endtask

  task automatic rdreg(input logic [31:0] a);
    cycle(0, a, 32'd0, 1, 0, cur_ext);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1, 32'd0, 32'd0, 0, 0, cur_ext);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (IrqOut !== e.irq) begin
          n_fail++; $display("FAIL irq_out t=%0t got=%0b exp=%0b", $time, IrqOut, e.irq);
        end
        if (IrqId !== e.id) begin
          n_fail++; $display("FAIL irq_id t=%0t got=%0d exp=%0d", $time, IrqId, e.id);
        end
        if (hit !== e.hit) begin
          n_fail++; $display("FAIL hit t=%0t addr=%h got=%0b exp=%0b", $time, address, hit, e.hit);
        end
        if (rd_data !== e.rd) begin
          n_fail++; $display("FAIL rd_data t=%0t addr=%h got=%h exp=%h", $time, address, rd_data, e.rd);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] a, d;
    int sel;
    cur_ext = 3'b000;
    do_reset(2);

    // Timer fires when counter reaches compare, then ACK drops IrqOut
    wr(ADDR_CYCLE, m_cnt + 32'd5);
    idle(7);
    wr(ADDR_MASK, 32'h1);
    rdreg(ADDR_PENDING);
    wr(ADDR_ACK, 32'h1);
    idle(2);

    // Masked source pends but does not raise IrqOut until enabled
    wr(ADDR_MASK, 32'h0);
    cur_ext = 3'b010;
    idle(4);
    rdreg(ADDR_PENDING);
    wr(ADDR_MASK, 32'h4);
    idle(1);
    wr(ADDR_ACK, 32'h4);
    cur_ext = 3'b000;

    // Priority between sources 1 and 3
    wr(ADDR_MASK, 32'hf);
    cur_ext = 3'b101;
    idle(4);
    wr(ADDR_ACK, 32'h2);
    idle(1);
    wr(ADDR_ACK, 32'h8);
    cur_ext = 3'b000;
    idle(3);

    // Set/ACK collision on source 1 (aligned to the detection edge)
    cur_ext = 3'b001;
    idle(DLY);
    wr(ADDR_ACK, 32'h2);
    rdreg(ADDR_PENDING);
    wr(ADDR_ACK, 32'h2);
    cur_ext = 3'b000;

    // Simultaneous load and store returns pre-write value
    cycle(0, ADDR_MASK, 32'h5, 1, 1, cur_ext);
    rdreg(ADDR_MASK);

    // Lines held high through reset do not fire; counter restarts
    cur_ext = 3'b111;
    idle(2);
    do_reset(2);
    rdreg(ADDR_CYCLE);
    wr(ADDR_MASK, 32'hf);
    idle(6);
    rdreg(ADDR_PENDING);

    // Level held across ACK does not re-trigger; low->high does
    cur_ext = 3'b000;
    idle(4);
    wr(ADDR_ACK, 32'hf);
    cur_ext = 3'b100;
    idle(4);
    wr(ADDR_ACK, 32'h8);
    idle(4);
    rdreg(ADDR_PENDING);
    cur_ext = 3'b000;
    idle(2);
    cur_ext = 3'b100;
    idle(4);
    rdreg(ADDR_PENDING);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = ADDR_CYCLE;
        1: a = ADDR_ACK;
        2, 3: a = ADDR_MASK;
        4: a = ADDR_PENDING;
        default: a = $urandom;
      endcase
      d = (a == ADDR_CYCLE) ? m_cnt + 32'($urandom_range(0, 20)) : $urandom;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) cur_ext[b] = ~cur_ext[b];
      if ($urandom_range(0, 199) == 0)
        cycle(1, a, d, 0, 0, cur_ext);
      else
        cycle(0, a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), cur_ext);
    end
    idle(2);
    drv_done = 1;
  end

  // Drain and summarise
  initial begin
    int waited;
    wait (drv_done);
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    @(negedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending_expectations exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports clock and reset.
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 address  in  32  memory-mapped I/O address from the datapath.
REQ-005 wr_data  in  32  store data.
REQ-006 MemRead  in  1  load strobe.
REQ-007 MemWrite  in  1  store strobe.
REQ-008 ext_irq  in  3  level interrupt lines for sources 1..3.
REQ-009 rd_data  out  32  read data for the decoded register; 0 when there is no hit.
REQ-010 hit  out  1  address matches one of the four controller registers.
REQ-011 IrqOut  out  1  interrupt request to the cp0 TimerInterrupt input.
REQ-012 IrqId  out  2  index of the highest-priority enabled pending source.

Function
REQ-013 SHALL keep a 32-bit free-running cycle counter that increments every cycle and wraps from 0xffffffff to 0.
REQ-014 Register map:
- CYCLE 0xffff001c: read returns the counter; write loads the 32-bit compare register.
- ACK 0xffff006c: write clears pending bits where wr_data[3:0] is 1.
- MASK 0xffff0070: read/write; bits [3:0] only.
- PENDING 0xffff0074: read-only.
REQ-015 Unused read bits SHALL return 0; writes to PENDING SHALL be ignored.
REQ-016 Reads SHALL be combinational; a write takes effect at the clock edge.
REQ-017 pending[0] SHALL set on the edge where counter == compare.
REQ-018 pending[n] (n=1..3) SHALL set on the edge where ext_irq[n-1] is 1 and the previous sampled value was 0 (rising edge only).
REQ-019 Set and ACK-clear of the same bit in the same cycle: set SHALL win.
REQ-020 IrqOut SHALL equal |(pending & mask), decoded combinationally from registered state.
REQ-021 IrqId SHALL be the lowest index with pending & mask set, and 0 when none.
REQ-022 Writing compare equal to the current counter value SHALL NOT fire that cycle; the compare takes effect from the next edge.
REQ-023 Re-firing SHALL require counter wrap-around or a new compare write; pending stays set until ACKed.
REQ-024 A source line held high SHALL NOT re-trigger until it drops and rises again.
REQ-025 When MemRead and MemWrite are both high, the write SHALL occur and rd_data SHALL show the pre-write value.

Reset
REQ-026 On reset: counter=0, compare=0xffffffff, mask=0, pending=0, IrqOut=0, IrqId=0.
REQ-027 Edge-detect flops SHALL load the current ext_irq during reset, so a line held high through reset does not fire.
REQ-028 Reset mid-operation SHALL discard pending and all in-flight edges.

Configuration
REQ-029 Macro IRQ_EXT_SYNC_EN SHALL control input synchronisation of ext_irq.
- Defined: ext_irq passes through two synchroniser flops before edge detection, adding 2 cycles of latency.
- Undefined: ext_irq feeds the edge detector directly; pending sets on the first edge that samples the rise.
- The timer path is unaffected either way.

Structure
REQ-030 Shared package irq_pkg SHALL hold the four address constants, NUM_SRC=4, the source index constants (SRC_TIMER=0, SRC_EXT1..3) and the ACK mask width.
REQ-031 Sub-module irq_edge_detect (one per external source) SHALL own the optional synchroniser, the previous-value flop and the rise pulse.

Verification
REQ-032 Timer: write CYCLE=10 at counter 5 -> pending=0x1 after counter reaches 10; IrqOut=1, IrqId=0; ACK 0x1 -> IrqOut=0 the next cycle.
REQ-033 Mask: mask=0, ext_irq[1] rises -> PENDING reads 0x4 and IrqOut=0; write mask=0x4 -> IrqOut=1, IrqId=2.
REQ-034 Priority: pending sources 3 and 1 with mask=0xf -> IrqId=1; ACK 0x2 -> IrqId=3.
REQ-035 Collision: ext_irq[0] rises in the same cycle as ACK 0x2 -> pending[1] remains 1.
REQ-036 Reset: ext_irq=3'b111 held through reset and after -> pending stays 0; counter reads 0 after reset; compare 0xffffffff fires only after 2^32-1 cycles (covered by forcing the counter).
REQ-037 Level hold: ext_irq[2] held high across an ACK -> no re-set; low then high -> pending[3] sets again (+2 cycles with IRQ_EXT_SYNC_EN).
